// File: rtl/probe_pkg.sv
// Shared definitions for the probe command path: FSM states, opcode classes
// and the opcode ranges that decide which class a command byte belongs to.
package probe_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StPayload,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    ClsRd,
    ClsWr,
    ClsOther
  } opc_class_e;

  // Read opcodes: no payload, one response byte
  localparam logic [7:0] OpRdALo = 8'd2;
  localparam logic [7:0] OpRdAHi = 8'd9;
  localparam logic [7:0] OpRdBLo = 8'd14;
  localparam logic [7:0] OpRdBHi = 8'd17;
  localparam logic [7:0] OpRdC   = 8'd22;
  localparam logic [7:0] OpRdD   = 8'd24;

  // Write opcodes: one payload byte, no response
  localparam logic [7:0] OpWrALo = 8'd10;
  localparam logic [7:0] OpWrAHi = 8'd13;
  localparam logic [7:0] OpWrBLo = 8'd18;
  localparam logic [7:0] OpWrBHi = 8'd21;
  localparam logic [7:0] OpWrC   = 8'd23;

endpackage

// File: rtl/probe_opcode_class.sv
// Combinational opcode classifier; shared between the arbiter and the probe.
module probe_opcode_class
  import probe_pkg::*;
(
  input  logic [7:0] opcode,
  output opc_class_e op_class
);

  // Anything outside the read and write ranges is a bare command
  always_comb begin
    op_class = ClsOther;
    if ((opcode >= OpRdALo && opcode <= OpRdAHi) ||
        (opcode >= OpRdBLo && opcode <= OpRdBHi) ||
        (opcode == OpRdC) || (opcode == OpRdD)) begin
      op_class = ClsRd;
    end else if ((opcode >= OpWrALo && opcode <= OpWrAHi) ||
                 (opcode >= OpWrBLo && opcode <= OpWrBHi) ||
                 (opcode == OpWrC)) begin
      op_class = ClsWr;
    end
  end

endmodule

// File: rtl/probe_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of a single byte-stream probe.
// A granted requester owns the probe for one whole packet (opcode, optional
// payload, optional response) so packets from the two sides never interleave.
module probe_cmd_arbiter
  import probe_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic       clk,
  input  logic       m_aresetn,
  // requester 0
  input  logic       s0_rx_valid,
  input  logic [7:0] s0_rx_data,
  output logic       s0_rx_ready,
  output logic       s0_tx_valid,
  output logic [7:0] s0_tx_data,
  input  logic       s0_tx_ready,
  // requester 1
  input  logic       s1_rx_valid,
  input  logic [7:0] s1_rx_data,
  output logic       s1_rx_ready,
  output logic       s1_tx_valid,
  output logic [7:0] s1_tx_data,
  input  logic       s1_tx_ready,
  // probe
  output logic       p_rx_valid,
  output logic [7:0] p_rx_data,
  input  logic       p_rx_ready,
  input  logic       p_tx_valid,
  input  logic [7:0] p_tx_data,
  output logic       p_tx_ready,
  // status
  output logic       owner,
  output logic       busy,
  output logic       timeout_err,
  output logic       stray_rsp
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(RSP_TIMEOUT);

  state_e           state_q;
  logic             owner_q;
  logic             last_owner_q;
  logic [CNT_W-1:0] timer_q;
  logic             timeout_err_q;
  logic             stray_rsp_q;

  opc_class_e cmd_class;
  logic       any_req;
  logic       grant_idx;
  logic       p_rx_hs;
  logic       p_tx_hs;

  probe_opcode_class u_opcode_class (
    .opcode   (p_rx_data),
    .op_class (cmd_class)
  );

  // On a tie the requester that did not win last time gets the grant
  always_comb begin
    any_req   = s0_rx_valid | s1_rx_valid;
    grant_idx = (s0_rx_valid & s1_rx_valid) ? ~last_owner_q : s1_rx_valid;
  end

  // Stream muxes; everything is forced low while reset is asserted
  always_comb begin
    p_rx_valid  = 1'b0;
    p_rx_data   = 8'h00;
    s0_rx_ready = 1'b0;
    s1_rx_ready = 1'b0;
    s0_tx_valid = 1'b0;
    s0_tx_data  = 8'h00;
    s1_tx_valid = 1'b0;
    s1_tx_data  = 8'h00;
    p_tx_ready  = 1'b0;
    if (m_aresetn) begin
      unique case (state_q)
        StIdle: begin
          // Sink anything the probe sends unprompted
          p_tx_ready = 1'b1;
        end
        StCmd, StPayload: begin
          p_rx_valid  = owner_q ? s1_rx_valid : s0_rx_valid;
          p_rx_data   = owner_q ? s1_rx_data  : s0_rx_data;
          s0_rx_ready = ~owner_q & p_rx_ready;
          s1_rx_ready =  owner_q & p_rx_ready;
        end
        StResp: begin
          s0_tx_valid = ~owner_q & p_tx_valid;
          s0_tx_data  = owner_q ? 8'h00 : p_tx_data;
          s1_tx_valid =  owner_q & p_tx_valid;
          s1_tx_data  = owner_q ? p_tx_data : 8'h00;
          p_tx_ready  = owner_q ? s1_tx_ready : s0_tx_ready;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    p_rx_hs = p_rx_valid & p_rx_ready;
    p_tx_hs = p_tx_valid & p_tx_ready;
  end

  // Packet FSM, response timer and registered status pulses
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      stray_rsp_q   <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      stray_rsp_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          stray_rsp_q <= p_tx_hs;
          if (any_req) begin
            owner_q      <= grant_idx;
            last_owner_q <= grant_idx;
            state_q      <= StCmd;
          end
        end
        StCmd: begin
          if (p_rx_hs) begin
            case (cmd_class)
              ClsWr: state_q <= StPayload;
              ClsRd: begin
                state_q <= StResp;
                timer_q <= '0;
              end
              default: state_q <= StIdle;
            endcase
          end
        end
        StPayload: begin
          if (p_rx_hs) state_q <= StIdle;
        end
        StResp: begin
          // A response arriving on the timeout cycle still completes normally
          if (p_tx_hs) begin
            state_q <= StIdle;
          end else if (timer_q == TimeoutVal) begin
            state_q       <= StIdle;
            timeout_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    owner       = owner_q;
    busy        = (state_q != StIdle);
    timeout_err = timeout_err_q;
    stray_rsp   = stray_rsp_q;
  end

endmodule

// File: tb/tb_probe_cmd_arbiter.sv
// Self-checking bench for probe_cmd_arbiter: directed scenarios plus random
// single-packet traffic checked against a transaction-level model.
module tb_probe_cmd_arbiter;

  localparam int unsigned TO = 12;
  localparam int unsigned CW = 4;
  localparam int ClsRd = 0;
  localparam int ClsWr = 1;
  localparam int ClsOther = 2;

  logic       clk = 1'b0;
  logic       m_aresetn;
  logic       s0_rx_valid, s0_rx_ready, s0_tx_valid, s0_tx_ready;
  logic [7:0] s0_rx_data, s0_tx_data;
  logic       s1_rx_valid, s1_rx_ready, s1_tx_valid, s1_tx_ready;
  logic [7:0] s1_rx_data, s1_tx_data;
  logic       p_rx_valid, p_rx_ready, p_tx_valid, p_tx_ready;
  logic [7:0] p_rx_data, p_tx_data;
  logic       owner, busy, timeout_err, stray_rsp;

  int errors = 0;
  int checks = 0;

  logic       mon_en = 1'b0;
  logic [7:0] mon_q[$];

  always #5 clk = ~clk;

  probe_cmd_arbiter #(
    .RSP_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .m_aresetn   (m_aresetn),
    .s0_rx_valid (s0_rx_valid),
    .s0_rx_data  (s0_rx_data),
    .s0_rx_ready (s0_rx_ready),
    .s0_tx_valid (s0_tx_valid),
    .s0_tx_data  (s0_tx_data),
    .s0_tx_ready (s0_tx_ready),
    .s1_rx_valid (s1_rx_valid),
    .s1_rx_data  (s1_rx_data),
    .s1_rx_ready (s1_rx_ready),
    .s1_tx_valid (s1_tx_valid),
    .s1_tx_data  (s1_tx_data),
    .s1_tx_ready (s1_tx_ready),
    .p_rx_valid  (p_rx_valid),
    .p_rx_data   (p_rx_data),
    .p_rx_ready  (p_rx_ready),
    .p_tx_valid  (p_tx_valid),
    .p_tx_data   (p_tx_data),
    .p_tx_ready  (p_tx_ready),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err),
    .stray_rsp   (stray_rsp)
  );

  // Record every byte the probe accepts, in order
  always @(posedge clk) begin
    if (mon_en && p_rx_valid && p_rx_ready) mon_q.push_back(p_rx_data);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s0_rx_valid = 1'b0; s0_rx_data = 8'h00; s0_tx_ready = 1'b0;
    s1_rx_valid = 1'b0; s1_rx_data = 8'h00; s1_tx_ready = 1'b0;
    p_rx_ready  = 1'b0; p_tx_valid = 1'b0; p_tx_data = 8'h00;
  endtask

  task automatic apply_reset();
    idle_inputs();
    m_aresetn = 1'b0;
    tick();
    tick();
    m_aresetn = 1'b1;
  endtask

  task automatic drive_rx(input int i, input logic v, input logic [7:0] d);
    if (i == 0) begin s0_rx_valid = v; s0_rx_data = d; end
    else begin s1_rx_valid = v; s1_rx_data = d; end
  endtask

  task automatic drive_tx_ready(input int i, input logic v);
    if (i == 0) s0_tx_ready = v;
    else s1_tx_ready = v;
  endtask

  function automatic logic rx_ready_of(input int i);
    return (i == 0) ? s0_rx_ready : s1_rx_ready;
  endfunction

  function automatic logic tx_valid_of(input int i);
    return (i == 0) ? s0_tx_valid : s1_tx_valid;
  endfunction

  function automatic logic [7:0] tx_data_of(input int i);
    return (i == 0) ? s0_tx_data : s1_tx_data;
  endfunction

  // Reference classification from the opcode tables
  function automatic int model_class(input logic [7:0] op);
    int rd_ops[14] = '{2, 3, 4, 5, 6, 7, 8, 9, 14, 15, 16, 17, 22, 24};
    int wr_ops[9]  = '{10, 11, 12, 13, 18, 19, 20, 21, 23};
    foreach (rd_ops[k]) if (int'(op) == rd_ops[k]) return ClsRd;
    foreach (wr_ops[k]) if (int'(op) == wr_ops[k]) return ClsWr;
    return ClsOther;
  endfunction

  task automatic test_reset();
    idle_inputs();
    m_aresetn = 1'b0;
    s0_rx_valid = 1'b1; s1_rx_valid = 1'b1; p_rx_ready = 1'b1; p_tx_valid = 1'b1;
    s0_tx_ready = 1'b1; s1_tx_ready = 1'b1;
    #1;
    checks++;
    if ({busy, owner, timeout_err, stray_rsp} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: got %b want 0000", {busy, owner, timeout_err, stray_rsp});
    end
    checks++;
    if ({p_rx_valid, s0_rx_ready, s1_rx_ready, s0_tx_valid, s1_tx_valid, p_tx_ready} !== 6'b0)
    begin
      errors++;
      $display("FAIL reset_handshakes: got %b want 000000",
               {p_rx_valid, s0_rx_ready, s1_rx_ready, s0_tx_valid, s1_tx_valid, p_tx_ready});
    end
    tick();
    checks++;
    if (busy !== 1'b0 || p_tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got busy=%b p_tx_ready=%b want 0 0", busy, p_tx_ready);
    end
    idle_inputs();
    m_aresetn = 1'b1;
    #1;
    checks++;
    if (p_tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got p_tx_ready=%b busy=%b want 1 0", p_tx_ready, busy);
    end
  endtask

  task automatic test_read();
    s0_rx_valid = 1'b1; s0_rx_data = 8'd6; p_rx_ready = 1'b1;
    #1;
    checks++;
    if (p_rx_valid !== 1'b0 || s0_rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_xfer: got p_rx_valid=%b s0_rx_ready=%b want 0 0",
               p_rx_valid, s0_rx_ready);
    end
    tick();
    #1;
    checks++;
    if (p_rx_valid !== 1'b1 || p_rx_data !== 8'd6 || s0_rx_ready !== 1'b1 || busy !== 1'b1)
    begin
      errors++;
      $display("FAIL read_cmd: got v=%b d=%0d rdy=%b busy=%b want 1 6 1 1",
               p_rx_valid, p_rx_data, s0_rx_ready, busy);
    end
    tick();
    idle_inputs();
    p_tx_valid = 1'b1; p_tx_data = 8'hA5; s0_tx_ready = 1'b1;
    #1;
    checks++;
    if (s0_tx_valid !== 1'b1 || s0_tx_data !== 8'hA5 || s1_tx_valid !== 1'b0 ||
        p_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_rsp: got v0=%b d0=%h v1=%b rdy=%b want 1 a5 0 1",
               s0_tx_valid, s0_tx_data, s1_tx_valid, p_tx_ready);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL read_done: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp[4];
    logic hs0, hs1;
    apply_reset();
    q0 = '{8'd10, 8'h3C};
    q1 = '{8'd11, 8'h55};
    exp = '{8'd10, 8'h3C, 8'd11, 8'h55};
    mon_q.delete();
    mon_en = 1'b1;
    p_rx_ready = 1'b1;
    for (int c = 0; c < 20 && (q0.size() != 0 || q1.size() != 0); c++) begin
      s0_rx_valid = (q0.size() != 0);
      s0_rx_data  = 8'h00;
      if (q0.size() != 0) s0_rx_data = q0[0];
      s1_rx_valid = (q1.size() != 0);
      s1_rx_data  = 8'h00;
      if (q1.size() != 0) s1_rx_data = q1[0];
      #1;
      hs0 = s0_rx_valid & s0_rx_ready;
      hs1 = s1_rx_valid & s1_rx_ready;
      tick();
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
    end
    idle_inputs();
    tick();
    mon_en = 1'b0;
    checks++;
    if (mon_q.size() != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d bytes want 4", mon_q.size());
    end
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      checks++;
      if (mon_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL rr_byte%0d: got %h want %h", i, mon_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int pulse_at;
    int pulses;
    idle_inputs();
    s1_rx_valid = 1'b1; s1_rx_data = 8'd22; p_rx_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (owner !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_grant: got owner=%b busy=%b want 1 1", owner, busy);
    end
    tick();
    idle_inputs();
    pulse_at = -1;
    pulses = 0;
    for (int n = 1; n <= int'(TO) + 3; n++) begin
      tick();
      if (timeout_err === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = n;
      end
      if (n == int'(TO)) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL to_busy_before: got %b want 1", busy);
        end
      end
      if (n == int'(TO) + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL to_busy_after: got %b want 0", busy);
        end
      end
    end
    checks++;
    if (pulse_at != int'(TO) + 1) begin
      errors++;
      $display("FAIL to_latency: got %0d want %0d", pulse_at, TO + 1);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL to_pulses: got %0d want 1", pulses);
    end
    s0_rx_valid = 1'b1; s0_rx_data = 8'd0; p_rx_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (owner !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_regrant: got owner=%b busy=%b want 0 1", owner, busy);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_rsp_at_timeout();
    idle_inputs();
    s0_rx_valid = 1'b1; s0_rx_data = 8'd2; p_rx_ready = 1'b1;
    tick();
    tick();
    idle_inputs();
    for (int n = 1; n <= int'(TO); n++) tick();
    p_tx_valid = 1'b1; p_tx_data = 8'h5A; s0_tx_ready = 1'b1;
    #1;
    checks++;
    if (s0_tx_valid !== 1'b1 || s0_tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL late_rsp_pass: got v=%b d=%h want 1 5a", s0_tx_valid, s0_tx_data);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_rsp_wins: got err=%b busy=%b want 0 0", timeout_err, busy);
    end
  endtask

  task automatic test_stray();
    int pulses;
    idle_inputs();
    p_tx_valid = 1'b1; p_tx_data = 8'h77;
    #1;
    checks++;
    if (p_tx_ready !== 1'b1 || s0_tx_valid !== 1'b0 || s1_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_accept: got rdy=%b v0=%b v1=%b want 1 0 0",
               p_tx_ready, s0_tx_valid, s1_tx_valid);
    end
    tick();
    idle_inputs();
    pulses = 0;
    checks++;
    if (stray_rsp !== 1'b1) begin
      errors++;
      $display("FAIL stray_pulse: got %b want 1", stray_rsp);
    end
    for (int n = 0; n < 3; n++) begin
      if (stray_rsp === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL stray_once: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    s0_rx_valid = 1'b1; s0_rx_data = 8'd10; p_rx_ready = 1'b1;
    tick();
    tick();
    s0_rx_data = 8'h99; s1_rx_valid = 1'b1; s1_rx_data = 8'd25;
    #1;
    checks++;
    if (busy !== 1'b1 || p_rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_payload: got busy=%b v=%b want 1 1", busy, p_rx_valid);
    end
    m_aresetn = 1'b0;
    #1;
    checks++;
    if ({busy, owner, p_rx_valid, s0_rx_ready, s1_rx_ready, p_tx_ready} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async_reset: got %b want 000000",
               {busy, owner, p_rx_valid, s0_rx_ready, s1_rx_ready, p_tx_ready});
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0 || stray_rsp !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_pulse: got err=%b stray=%b want 0 0", timeout_err, stray_rsp);
    end
    s0_rx_data = 8'd25;
    m_aresetn = 1'b1;
    tick();
    #1;
    checks++;
    if (owner !== 1'b0 || busy !== 1'b1 || p_rx_data !== 8'd25) begin
      errors++;
      $display("FAIL mid_tie: got owner=%b busy=%b d=%0d want 0 1 25", owner, busy, p_rx_data);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_done: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_other_then_read();
    idle_inputs();
    s0_rx_valid = 1'b1; s0_rx_data = 8'd25; p_rx_ready = 1'b1;
    tick();
    tick();
    s0_rx_data = 8'd2;
    #1;
    checks++;
    if (busy !== 1'b0 || s0_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL other_no_rsp: got busy=%b v0=%b want 0 0", busy, s0_tx_valid);
    end
    tick();
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b1 || p_rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_in_resp: got busy=%b p_rx_valid=%b want 1 0", busy, p_rx_valid);
    end
    p_tx_valid = 1'b1; p_tx_data = 8'h3C; s0_tx_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [1:0] req;
    logic [7:0] ops[2];
    logic [7:0] pl, rb;
    int m_last, w, l, cls, stall;
    apply_reset();
    m_last = 1;
    for (int it = 0; it < 60; it++) begin
      req = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++)
        ops[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 27));
      idle_inputs();
      drive_rx(0, req[0], ops[0]);
      drive_rx(1, req[1], ops[1]);
      #1;
      checks++;
      if (busy !== 1'b0 || p_rx_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_idle it%0d: got busy=%b v=%b want 0 0", it, busy, p_rx_valid);
      end
      tick();
      if (req == 2'b11) w = 1 - m_last;
      else w = (req == 2'b10) ? 1 : 0;
      l = 1 - w;
      m_last = w;
      #1;
      checks++;
      if (owner !== 1'(w) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rnd_grant it%0d: got owner=%b busy=%b want %0d 1", it, owner, busy, w);
      end
      stall = $urandom_range(0, 2);
      repeat (stall) begin
        checks++;
        if (p_rx_valid !== 1'b1 || p_rx_data !== ops[w] || s0_rx_ready !== 1'b0 ||
            s1_rx_ready !== 1'b0) begin
          errors++;
          $display("FAIL rnd_stall it%0d: got v=%b d=%h want 1 %h", it, p_rx_valid,
                   p_rx_data, ops[w]);
        end
        tick();
        #1;
      end
      p_rx_ready = 1'b1;
      #1;
      checks++;
      if (rx_ready_of(w) !== 1'b1 || rx_ready_of(l) !== 1'b0 || p_rx_data !== ops[w]) begin
        errors++;
        $display("FAIL rnd_cmd it%0d: got rdy_w=%b rdy_l=%b d=%h want 1 0 %h", it,
                 rx_ready_of(w), rx_ready_of(l), p_rx_data, ops[w]);
      end
      tick();
      idle_inputs();
      cls = model_class(ops[w]);
      if (cls == ClsWr) begin
        if ($urandom_range(0, 1) == 1) begin
          #1;
          checks++;
          if (busy !== 1'b1 || owner !== 1'(w) || p_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_gap it%0d: got busy=%b owner=%b v=%b want 1 %0d 0", it, busy,
                     owner, p_rx_valid, w);
          end
          tick();
        end
        pl = 8'($urandom);
        drive_rx(w, 1'b1, pl);
        p_rx_ready = 1'b1;
        #1;
        checks++;
        if (p_rx_valid !== 1'b1 || p_rx_data !== pl) begin
          errors++;
          $display("FAIL rnd_payload it%0d: got v=%b d=%h want 1 %h", it, p_rx_valid,
                   p_rx_data, pl);
        end
        tick();
        idle_inputs();
      end else if (cls == ClsRd) begin
        repeat ($urandom_range(0, 5)) begin
          #1;
          checks++;
          if (s0_tx_valid !== 1'b0 || s1_tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rnd_wait it%0d: got v0=%b v1=%b busy=%b want 0 0 1", it,
                     s0_tx_valid, s1_tx_valid, busy);
          end
          tick();
        end
        rb = 8'($urandom);
        p_tx_valid = 1'b1;
        p_tx_data  = rb;
        drive_tx_ready(w, 1'b1);
        #1;
        checks++;
        if (tx_valid_of(w) !== 1'b1 || tx_data_of(w) !== rb || tx_valid_of(l) !== 1'b0 ||
            p_tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL rnd_rsp it%0d: got vw=%b dw=%h vl=%b rdy=%b want 1 %h 0 1", it,
                   tx_valid_of(w), tx_data_of(w), tx_valid_of(l), p_tx_ready, rb);
        end
        tick();
        idle_inputs();
      end
      #1;
      checks++;
      if (busy !== 1'b0 || timeout_err !== 1'b0 || stray_rsp !== 1'b0) begin
        errors++;
        $display("FAIL rnd_end it%0d cls%0d: got busy=%b err=%b stray=%b want 0 0 0", it, cls,
                 busy, timeout_err, stray_rsp);
      end
    end
  endtask

  initial begin
    idle_inputs();
    m_aresetn = 1'b0;
    @(negedge clk);
    test_reset();
    test_read();
    test_round_robin();
    test_timeout();
    test_rsp_at_timeout();
    test_stray();
    test_reset_mid();
    test_other_then_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
